rom_loader: RTL and testbench
=============================

# rom_loader

Parametrised download router between the HPS ioctl stream and the core's memory regions (ROMs and cartridge images). Maps each `ioctl_index` to one of NUM_REGIONS targets, buffers one byte and converts the one-cycle `ioctl_wr` strobe into a req/ack write, back-pressuring the HPS via `ioctl_wait`. It also generates the system reset hold that spans a download plus a settle period. It sits between `hps_io` and the machine module in the emu top level.

## Interface
- NUM_REGIONS, 2, number of target regions; region k is selected by `ioctl_index == k+1`; index 0 and indices > NUM_REGIONS are ignored
- ADDR_W, 16, region address width; bytes at `ioctl_addr >= 2**ADDR_W` are discarded
- HOLD_CYCLES, 1024, cycles `hold_reset_o` stays high after download end (≥1)
- clk_i  in  1  system clock
- reset_n_i  in  1  asynchronous active-low reset
- ioctl_download_i  in  1  download active
- ioctl_index_i  in  8  download target index
- ioctl_wr_i  in  1  one-cycle byte strobe
- ioctl_addr_i  in  25  byte address within download
- ioctl_dout_i  in  8  byte data
- ioctl_wait_o  out  1  stall request to HPS
- mem_req_o  out  1  write request, held until ack
- mem_region_o  out  $clog2(NUM_REGIONS) (min 1)  target region
- mem_addr_o  out  ADDR_W  write address
- mem_data_o  out  8  write data
- mem_ack_i  in  1  write accepted this cycle
- hold_reset_o  out  1  keep machine in reset
- region_loaded_o  out  NUM_REGIONS  sticky: region received ≥1 byte in a completed download
- overflow_o  out  1  sticky: out-of-range address seen
- overrun_o  out  1  sticky: `ioctl_wr_i` while a write was pending
- checksum_o  out  8  running byte sum of current/last download (only with LOADER_CHECKSUM_EN)

## Operation
- FSM states: IDLE, LOAD, PEND, HOLD.
- IDLE: `ioctl_download_i` rising with mapped index -> LOAD; latch region, clear checksum, clear per-download "byte seen" flag.
- LOAD: `ioctl_wr_i` with in-range address -> capture addr[ADDR_W-1:0]/data into buffer, go PEND. Out-of-range -> set overflow_o, stay LOAD.
- PEND: `mem_req_o` high; on `mem_ack_i` -> LOAD, byte counted. `ioctl_wr_i` in PEND: byte dropped, overrun_o set.
- Download falling edge in LOAD -> HOLD; if byte seen set `region_loaded_o[region]`. Falling edge in PEND: finish pending write first, then HOLD.
- HOLD: counts HOLD_CYCLES, then IDLE. New mapped download start in HOLD -> LOAD, counter discarded.
- Unmapped index downloads: no writes, no wait, no hold, flags untouched.
- Sticky flags clear only on reset; region_loaded_o bit is never cleared by a later download of another region.

## Timing
- Reset values: ioctl_wait_o 0, mem_req_o 0, mem_region_o 0, mem_addr_o 0, mem_data_o 0, hold_reset_o 0, region_loaded_o 0, overflow_o 0, overrun_o 0, checksum_o 0; state IDLE.
- `ioctl_wr_i` sampled at edge N -> mem_req_o/addr/data valid from N+1.
- ioctl_wait_o is registered and equal to mem_req_o.
- Ack at edge M -> mem_req_o low from M+1; ack in the same cycle req rises completes the write (single-cycle req).
- mem_addr_o/mem_data_o/mem_region_o stable while mem_req_o is high.
- hold_reset_o high from cycle after download rise through exactly HOLD_CYCLES cycles after HOLD entry.
- Reset asserted mid-PEND: request dropped immediately (async), no partial state retained.

## Configuration
- LOADER_CHECKSUM_EN defined: checksum_o = mod-256 sum of every acked byte since last download start; updated the cycle after ack.
- Undefined: checksum_o port absent, adder removed.

## Structure
- Package `rom_loader_pkg`: state enum (IDLE, LOAD, PEND, HOLD), index-to-region mapping function, ioctl width localparams (address 25, data 8).
- Sub-module `loader_hold_timer`: loadable down-counter for HOLD_CYCLES with `start`, `busy` outputs.

## Test plan
- Index 1, bytes 0x00..0x03 at addr 0..3, ack 1 cycle after req -> four writes region 0, data matches, region_loaded_o=01, hold_reset_o drops HOLD_CYCLES after download end.
- Ack delayed 5 cycles -> ioctl_wait_o high for 6 cycles per byte; second wr during pend -> overrun_o=1, byte absent.
- ADDR_W=16, addr 0x10000 -> no mem_req_o, overflow_o=1; addr 0xFFFF written normally.
- Index 7 (unmapped) download -> no req, no wait, hold_reset_o stays 0.
- reset_n_i low while mem_req_o high -> all outputs zero same cycle; after release fresh download works.
- LOADER_CHECKSUM_EN: bytes 0xFF,0x02 -> checksum_o=0x01; new download start -> 0x00.

Source files
------------

// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared state type, ioctl widths and index mapping for the
// HPS download router.
package rom_loader_pkg;

   localparam int IOCTL_ADDR_W  = 25;
   localparam int IOCTL_DATA_W  = 8;
   localparam int IOCTL_INDEX_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      PEND = 2'd2,
      HOLD = 2'd3
   } state_t;

   // Index k+1 selects region k; index 0 and anything past the last region
   // belongs to someone else (config files, save RAM, ...).
   function automatic logic index_mapped(input logic [IOCTL_INDEX_W-1:0] idx,
                                         input int num_regions);
      return (idx != '0) && (int'(32'(idx)) <= num_regions);
   endfunction

endpackage

// File: rtl/loader_hold_timer.sv
// loader_hold_timer: loadable down-counter that times the post-download
// reset hold. busy_o stays high for HOLD_CYCLES-1 cycles after start_i, so a
// state machine that leaves on !busy_o spends exactly HOLD_CYCLES cycles in
// its hold state.
module loader_hold_timer #(
   parameter int HOLD_CYCLES = 1024
)(
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic start_i,
   output logic busy_o
);

   localparam int CW = $clog2(HOLD_CYCLES + 1);

   logic [CW-1:0] cnt_q;

   // Reload on start, otherwise count down to zero and park there.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)          cnt_q <= '0;
      else if (start_i)        cnt_q <= CW'(HOLD_CYCLES - 1);
      else if (cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
   end

   assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/rom_loader.sv
// rom_loader: routes the HPS ioctl byte stream into one of NUM_REGIONS
// memory regions through a one-byte req/ack buffer, stalls the HPS while a
// write is outstanding and holds the machine in reset across a download plus
// a settle period.
// Optional feature: define LOADER_CHECKSUM_EN to add checksum_o, a mod-256
// sum of every acked byte since the last download start.
module rom_loader
   import rom_loader_pkg::*;
#(
   parameter  int NUM_REGIONS = 2,
   parameter  int ADDR_W      = 16,
   parameter  int HOLD_CYCLES = 1024,
   localparam int RW          = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
)(
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     ioctl_download_i,
   input  logic [IOCTL_INDEX_W-1:0] ioctl_index_i,
   input  logic                     ioctl_wr_i,
   input  logic [IOCTL_ADDR_W-1:0]  ioctl_addr_i,
   input  logic [IOCTL_DATA_W-1:0]  ioctl_dout_i,
   output logic                     ioctl_wait_o,
   output logic                     mem_req_o,
   output logic [RW-1:0]            mem_region_o,
   output logic [ADDR_W-1:0]        mem_addr_o,
   output logic [IOCTL_DATA_W-1:0]  mem_data_o,
   input  logic                     mem_ack_i,
   output logic                     hold_reset_o,
   output logic [NUM_REGIONS-1:0]   region_loaded_o,
   output logic                     overflow_o,
   output logic                     overrun_o
`ifdef LOADER_CHECKSUM_EN
  ,output logic [7:0]               checksum_o
`endif
);

   state_t        state_q, state_nxt;
   logic          dl_q, dl_rise, idx_ok, in_range;
   logic [RW-1:0] dl_region;
   logic          dl_start, cap, acked, dl_done, ovf_set, ovr_set;
   logic          hold_start, timer_busy, seen_q;

   assign dl_rise   = ioctl_download_i & ~dl_q;
   assign idx_ok    = index_mapped(ioctl_index_i, NUM_REGIONS);
   assign dl_region = RW'(ioctl_index_i - 8'd1);
   assign in_range  = ((ioctl_addr_i >> ADDR_W) == '0);

   // Reset hold covers the whole download and the settle period.
   assign hold_reset_o = (state_q != IDLE);

   // State register; req/wait are registered copies of "next state is PEND".
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q      <= IDLE;
         dl_q         <= 1'b0;
         mem_req_o    <= 1'b0;
         ioctl_wait_o <= 1'b0;
      end else begin
         state_q      <= state_nxt;
         dl_q         <= ioctl_download_i;
         mem_req_o    <= (state_nxt == PEND);
         ioctl_wait_o <= (state_nxt == PEND);
      end
   end

   // Next-state and event decode. A falling download in PEND waits for the
   // ack before moving to HOLD so the last byte is never lost.
   always_comb begin
      state_nxt  = state_q;
      dl_start   = 1'b0;
      cap        = 1'b0;
      acked      = 1'b0;
      dl_done    = 1'b0;
      ovf_set    = 1'b0;
      ovr_set    = 1'b0;
      hold_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (dl_rise && idx_ok) begin
               state_nxt = LOAD;
               dl_start  = 1'b1;
            end
         end
         LOAD: begin
            if (!ioctl_download_i) begin
               state_nxt  = HOLD;
               dl_done    = 1'b1;
               hold_start = 1'b1;
            end else if (ioctl_wr_i) begin
               if (in_range) begin
                  cap       = 1'b1;
                  state_nxt = PEND;
               end else begin
                  ovf_set   = 1'b1;
               end
            end
         end
         PEND: begin
            ovr_set = ioctl_wr_i;
            if (mem_ack_i) begin
               acked = 1'b1;
               if (ioctl_download_i) begin
                  state_nxt  = LOAD;
               end else begin
                  state_nxt  = HOLD;
                  dl_done    = 1'b1;
                  hold_start = 1'b1;
               end
            end
         end
         HOLD: begin
            if (dl_rise && idx_ok) begin
               state_nxt = LOAD;
               dl_start  = 1'b1;
            end else if (!timer_busy) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Write buffer, per-download bookkeeping and sticky status flags.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         mem_region_o    <= '0;
         mem_addr_o      <= '0;
         mem_data_o      <= '0;
         seen_q          <= 1'b0;
         region_loaded_o <= '0;
         overflow_o      <= 1'b0;
         overrun_o       <= 1'b0;
      end else begin
         if (dl_start) begin
            mem_region_o <= dl_region;
            seen_q       <= 1'b0;
         end
         if (cap) begin
            mem_addr_o <= ioctl_addr_i[ADDR_W-1:0];
            mem_data_o <= ioctl_dout_i;
         end
         if (acked)
            seen_q <= 1'b1;
         if (dl_done && (seen_q || acked))
            region_loaded_o[mem_region_o] <= 1'b1;
         if (ovf_set)
            overflow_o <= 1'b1;
         if (ovr_set)
            overrun_o <= 1'b1;
      end
   end

`ifdef LOADER_CHECKSUM_EN
   // Running sum of acked bytes, restarted on every mapped download start.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)     checksum_o <= '0;
      else if (dl_start)  checksum_o <= '0;
      else if (acked)     checksum_o <= checksum_o + mem_data_o;
   end
`endif

   loader_hold_timer #(
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_hold_timer (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .start_i   (hold_start),
      .busy_o    (timer_busy)
   );

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: randomized bench for rom_loader. An HPS driver issues
// downloads, a memory responder acks with a programmable delay and records
// every accepted write, and a transaction-level model predicts the writes,
// sticky flags, reset hold length and (with LOADER_CHECKSUM_EN) checksum.
module tb_rom_loader;

   localparam int NR   = 2;
   localparam int AW   = 16;
   localparam int HOLD = 8;

   logic        clk_i, reset_n_i;
   logic        ioctl_download_i, ioctl_wr_i;
   logic [7:0]  ioctl_index_i, ioctl_dout_i;
   logic [24:0] ioctl_addr_i;
   logic        ioctl_wait_o, mem_req_o, mem_ack_i, hold_reset_o;
   logic        mem_region_o;
   logic [15:0] mem_addr_o;
   logic [7:0]  mem_data_o;
   logic [1:0]  region_loaded_o;
   logic        overflow_o, overrun_o;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  checksum_o;
`endif

   rom_loader #(.NUM_REGIONS(NR), .ADDR_W(AW), .HOLD_CYCLES(HOLD)) dut (
      .clk_i            (clk_i),
      .reset_n_i        (reset_n_i),
      .ioctl_download_i (ioctl_download_i),
      .ioctl_index_i    (ioctl_index_i),
      .ioctl_wr_i       (ioctl_wr_i),
      .ioctl_addr_i     (ioctl_addr_i),
      .ioctl_dout_i     (ioctl_dout_i),
      .ioctl_wait_o     (ioctl_wait_o),
      .mem_req_o        (mem_req_o),
      .mem_region_o     (mem_region_o),
      .mem_addr_o       (mem_addr_o),
      .mem_data_o       (mem_data_o),
      .mem_ack_i        (mem_ack_i),
      .hold_reset_o     (hold_reset_o),
      .region_loaded_o  (region_loaded_o),
      .overflow_o       (overflow_o),
      .overrun_o        (overrun_o)
`ifdef LOADER_CHECKSUM_EN
     ,.checksum_o       (checksum_o)
`endif
   );

   int total, bad;
   int ack_dly;

   // reference model state
   logic [31:0] exp_q[$];
   logic [31:0] obs_q[$];
   logic        m_mapped, m_region, m_ovf, m_ovr;
   logic [1:0]  m_loaded;
   logic [7:0]  m_sum;
   int          m_cnt;

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] pack(input logic r, input logic [15:0] a, input logic [7:0] d);
      return {7'd0, r, a, d};
   endfunction

   // stall must mirror the request at all times
   initial forever begin
      @(negedge clk_i);
      chk("wait_eq_req", 32'(ioctl_wait_o), 32'(mem_req_o));
   end

   // memory responder: ack ack_dly cycles after seeing req, record the write
   initial begin
      logic [31:0] w;
      mem_ack_i = 1'b0;
      forever begin
         @(negedge clk_i);
         if (mem_req_o === 1'b1 && reset_n_i === 1'b1) begin
            w = pack(mem_region_o, mem_addr_o, mem_data_o);
            for (int i = 0; i < ack_dly; i++) begin
               @(negedge clk_i);
               if (mem_req_o === 1'b1)
                  chk("req_stable", pack(mem_region_o, mem_addr_o, mem_data_o), w);
            end
            if (mem_req_o === 1'b1) obs_q.push_back(w);
            mem_ack_i = 1'b1;
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            if (reset_n_i === 1'b1) chk("req_drop", 32'(mem_req_o), 32'd0);
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic dl_begin(input logic [7:0] idx);
      m_mapped = (idx >= 8'd1) && (idx <= 8'(NR));
      if (m_mapped) begin
         m_region = 1'(idx - 8'd1);
         m_cnt    = 0;
         m_sum    = 8'd0;
      end
      @(posedge clk_i); #1;
      ioctl_index_i    = idx;
      ioctl_download_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      chk("hold_rise", 32'(hold_reset_o), 32'(m_mapped));
`ifdef LOADER_CHECKSUM_EN
      if (m_mapped) chk("sum_clear", 32'(checksum_o), 32'd0);
`endif
   endtask

   task automatic wait_free();
      int n = 0;
      while (ioctl_wait_o === 1'b1 && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 200) chk("wait_stuck", 32'(ioctl_wait_o), 32'd0);
   endtask

   // force_wr: strobe without honouring ioctl_wait_o (overrun case)
   task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit force_wr);
      logic inr;
      if (!force_wr) wait_free();
      @(posedge clk_i); #1;
      ioctl_wr_i   = 1'b1;
      ioctl_addr_i = a;
      ioctl_dout_i = d;
      @(posedge clk_i); #1;
      ioctl_wr_i   = 1'b0;
      inr = ((a >> AW) == 25'd0);
      if (force_wr) begin
         if (m_mapped) m_ovr = 1'b1;
      end else if (m_mapped) begin
         if (inr) begin
            exp_q.push_back(pack(m_region, a[15:0], d));
            m_sum = m_sum + d;
            m_cnt++;
         end else begin
            m_ovf = 1'b1;
         end
      end
      if (!force_wr) begin
         @(negedge clk_i);
         chk("req_rise", 32'(mem_req_o), 32'(m_mapped && inr));
      end
   endtask

   // called at a negedge where ioctl_wait_o is already high
   task automatic wait_len(input int want);
      int n = 1;
      @(negedge clk_i);
      while (ioctl_wait_o === 1'b1 && n < 100) begin
         n++;
         @(negedge clk_i);
      end
      chk("wait_len", 32'(n), 32'(want));
   endtask

   // drain: drop download only once no write is pending
   task automatic dl_end(input bit drain, input bit wait_hold);
      int n;
      if (drain) wait_free();
      @(posedge clk_i); #1;
      ioctl_download_i = 1'b0;
      @(posedge clk_i);
      if (m_mapped && m_cnt > 0) m_loaded[m_region] = 1'b1;
      if (wait_hold) begin
         n = 0;
         @(negedge clk_i);
         while (hold_reset_o === 1'b1 && n < 4*HOLD + 64) begin
            n++;
            @(negedge clk_i);
         end
         if (drain) chk("hold_len", 32'(n), m_mapped ? 32'(HOLD) : 32'd0);
         else       chk("hold_end", 32'(hold_reset_o), 32'd0);
      end
      chk("n_writes", 32'(obs_q.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0 && obs_q.size() > 0)
         chk("write", obs_q.pop_front(), exp_q.pop_front());
      exp_q.delete();
      obs_q.delete();
      chk("loaded", 32'(region_loaded_o), 32'(m_loaded));
      chk("overflow", 32'(overflow_o), 32'(m_ovf));
      chk("overrun", 32'(overrun_o), 32'(m_ovr));
`ifdef LOADER_CHECKSUM_EN
      chk("checksum", 32'(checksum_o), 32'(m_sum));
`endif
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req"},    32'(mem_req_o), 32'd0);
      chk({tag, "_wait"},   32'(ioctl_wait_o), 32'd0);
      chk({tag, "_hold"},   32'(hold_reset_o), 32'd0);
      chk({tag, "_buf"},    pack(mem_region_o, mem_addr_o, mem_data_o), 32'd0);
      chk({tag, "_loaded"}, 32'(region_loaded_o), 32'd0);
      chk({tag, "_ovf"},    32'(overflow_o), 32'd0);
      chk({tag, "_ovr"},    32'(overrun_o), 32'd0);
`ifdef LOADER_CHECKSUM_EN
      chk({tag, "_sum"},    32'(checksum_o), 32'd0);
`endif
   endtask

   initial begin
      logic [7:0]  ix;
      logic [24:0] a;
      int          nb;
      total = 0; bad = 0;
      reset_n_i = 1'b0; ioctl_download_i = 1'b0; ioctl_index_i = 8'd0;
      ioctl_wr_i = 1'b0; ioctl_addr_i = 25'd0; ioctl_dout_i = 8'd0;
      ack_dly = 0;
      m_mapped = 1'b0; m_region = 1'b0; m_ovf = 1'b0; m_ovr = 1'b0;
      m_loaded = 2'b00; m_sum = 8'd0; m_cnt = 0;
      repeat (3) @(negedge clk_i);
      chk_all_zero("rst");
      reset_n_i = 1'b1;

      // four bytes into region 0, ack one cycle after req
      ack_dly = 1;
      dl_begin(8'd1);
      for (int i = 0; i < 4; i++) send_byte(25'(i), 8'(i), 1'b0);
      dl_end(1'b1, 1'b1);
      chk("loaded_01", 32'(region_loaded_o), 32'd1);

      // slow ack: 6-cycle stall per byte, strobe during pend is dropped
      ack_dly = 5;
      dl_begin(8'd2);
      send_byte(25'h20, 8'hA5, 1'b0);
      send_byte(25'h21, 8'h3C, 1'b1);
      send_byte(25'h22, 8'h11, 1'b0);
      wait_len(6);
      dl_end(1'b1, 1'b1);

      // address boundary
      ack_dly = 0;
      dl_begin(8'd1);
      send_byte(25'h10000, 8'h77, 1'b0);
      send_byte(25'h0FFFF, 8'h88, 1'b0);
      dl_end(1'b1, 1'b1);

      // unmapped index
      dl_begin(8'd7);
      for (int i = 0; i < 3; i++) send_byte(25'(i), 8'hC0, 1'b0);
      dl_end(1'b1, 1'b1);

      // checksum wrap
      dl_begin(8'd1);
      send_byte(25'h100, 8'hFF, 1'b0);
      send_byte(25'h101, 8'h02, 1'b0);
      dl_end(1'b1, 1'b1);
`ifdef LOADER_CHECKSUM_EN
      chk("sum_ff02", 32'(checksum_o), 32'h01);
`endif

      // download ends while the last write is still pending
      ack_dly = 4;
      dl_begin(8'd2);
      send_byte(25'h5, 8'h42, 1'b0);
      dl_end(1'b0, 1'b1);

      // new download restarts from HOLD
      ack_dly = 0;
      dl_begin(8'd1);
      send_byte(25'h7, 8'h13, 1'b0);
      dl_end(1'b1, 1'b0);
      repeat (3) @(posedge clk_i);
      dl_begin(8'd2);
      send_byte(25'h8, 8'h14, 1'b0);
      dl_end(1'b1, 1'b1);

      // randomized downloads
      for (int t = 0; t < 24; t++) begin
         ack_dly = $urandom_range(0, 3);
         case ($urandom_range(0, 5))
            0:       ix = 8'd0;
            1:       ix = 8'd3;
            2, 3:    ix = 8'd1;
            default: ix = 8'd2;
         endcase
         nb = $urandom_range(0, 6);
         dl_begin(ix);
         for (int b = 0; b < nb; b++) begin
            a = {9'd0, 16'($urandom)};
            if ($urandom_range(0, 7) == 0) a[24:16] = 9'($urandom_range(1, 511));
            send_byte(a, 8'($urandom), 1'b0);
         end
         dl_end(1'b1, 1'b1);
      end

      // reset while a write is pending
      ack_dly = 6;
      dl_begin(8'd2);
      send_byte(25'h30, 8'h99, 1'b0);
      @(negedge clk_i);
      chk("pend_before_rst", 32'(mem_req_o), 32'd1);
      reset_n_i = 1'b0;
      #1;
      chk_all_zero("async_rst");
      ioctl_download_i = 1'b0;
      m_loaded = 2'b00; m_ovf = 1'b0; m_ovr = 1'b0; m_sum = 8'd0;
      repeat (12) @(negedge clk_i);
      reset_n_i = 1'b1;
      exp_q.delete();
      obs_q.delete();
      ack_dly = 1;
      dl_begin(8'd1);
      send_byte(25'h40, 8'h21, 1'b0);
      send_byte(25'h41, 8'h43, 1'b0);
      dl_end(1'b1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
